// File: rtl/apb_pkg.sv
// Shared APB types: bus FSM states and data width.
// The APB memory slave imports the same state enum.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response and APB bus signals of the APB requester.
// Two views: master (the requester) and slave (sequencer plus APB slave side).
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned addrWidth = 12
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [addrWidth-1:0]  req_addr;
  logic [APB_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [addrWidth-1:0]  paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states; flags expiry after TIMEOUT cycles without pready.
// TIMEOUT = 0 disables expiry.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] r_cnt;

  // Holds at the expiry value so the count never wraps.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_cnt == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers and
// returns a one-cycle response, aborting with an error if pready never comes.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned addrWidth = 12,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic         pclk,
  input logic         presetn,
  apb_master_if.master bus
);

  apb_state_e r_state, w_state_d;

  logic                  r_pwrite;
  logic [addrWidth-1:0]  r_paddr;
  logic [APB_DATA_W-1:0] r_pwdata;
  logic                  r_rsp_valid, w_rsp_valid_d;
  logic [APB_DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic                  r_rsp_err, w_rsp_err_d;
  logic                  w_accept;
  logic                  w_expired;

  // Bus strobes decode from the state register only.
  assign bus.psel    = (r_state != IDLE);
  assign bus.penable = (r_state == ACCESS);
  assign bus.pwrite  = r_pwrite;
  assign bus.paddr   = r_paddr;
  assign bus.pwdata  = r_pwdata;

  // pready reaches req_ready only here; the abort cycle has pready low so never accepts.
  assign bus.req_ready = presetn && ((r_state == IDLE) || ((r_state == ACCESS) && bus.pready));
  assign w_accept      = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_clear   (w_accept),
    .i_enable  ((r_state == ACCESS) && !bus.pready),
    .o_expired (w_expired)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_rsp_valid_d = 1'b0;
    w_rsp_rdata_d = '0;
    w_rsp_err_d   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_d = SETUP;
      end
      SETUP: begin
        w_state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = r_pwrite ? '0 : bus.prdata;
          w_state_d     = w_accept ? SETUP : IDLE;
        end else if (w_expired) begin
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = 1'b1;
          w_state_d     = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pwrite <= bus.req_write;
        r_paddr  <= bus.req_addr;
        r_pwdata <= bus.req_write ? bus.req_wdata : '0;
      end
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small APB memory slave model with
// programmable wait states and a stall switch.
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned TO = 16;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_if #(.addrWidth(AW)) bus ();

  apb_master #(
    .addrWidth (AW),
    .TIMEOUT   (TO)
  ) u_dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  // Slave model: unwritten locations read back a recognisable non-zero pattern.
  logic [31:0] mem       [0:4095];
  bit          mem_valid [0:4095];
  int unsigned n_waits     = 0;
  logic        force_stall = 1'b0;
  int unsigned r_wcnt      = 0;

  assign bus.pready = bus.psel && bus.penable && !force_stall && (r_wcnt >= n_waits);
  assign bus.prdata = mem_valid[bus.paddr] ? mem[bus.paddr] : {20'hBAD00, bus.paddr};

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) r_wcnt <= r_wcnt + 1;
    else r_wcnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
      mem[bus.paddr]       <= bus.pwdata;
      mem_valid[bus.paddr] <= 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer; latency counted in cycles after the accepting edge.
  task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_lat, input int exp_access);
    int   guard;
    int   lat;
    int   n_setup;
    int   n_access;
    logic addr_ok;
    logic ctl_ok;
    @(negedge pclk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    #1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge pclk);
      #1;
      guard++;
    end
    check({tag, "_accept"}, bus.req_ready, 1'b1);
    @(posedge pclk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hFFFF_FFFF;
    lat      = 0;
    n_setup  = 0;
    n_access = 0;
    addr_ok  = 1'b1;
    ctl_ok   = 1'b1;
    do begin
      @(negedge pclk);
      lat++;
      if (bus.psel && !bus.penable) n_setup++;
      if (bus.psel && bus.penable) n_access++;
      if (bus.psel && (bus.paddr !== addr)) addr_ok = 1'b0;
      if (bus.psel && ((bus.pwrite !== wr) || (bus.pwdata !== (wr ? wdata : 32'h0))))
        ctl_ok = 1'b0;
    end while (!bus.rsp_valid && lat < 100);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_setup_cycles"}, n_setup, 1);
    check({tag, "_access_cycles"}, n_access, exp_access);
    check({tag, "_paddr_stable"}, addr_ok, 1'b1);
    check({tag, "_pwrite_pwdata"}, ctl_ok, 1'b1);
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err"}, bus.rsp_err, exp_err);
    @(negedge pclk);
    check({tag, "_rsp_single"}, bus.rsp_valid, 1'b0);
  endtask

  logic [AW-1:0] b2b_addr [3];
  logic [31:0]   b2b_data [3];
  logic [15:0]   psel_tr;
  logic [15:0]   rsp_tr;
  int            b2b_idx;
  logic          b2b_acc;
  int            n_bad;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    b2b_addr = '{12'h001, 12'h002, 12'h003};
    b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    // Reset values
    #3;
    check("rst_psel", bus.psel, 1'b0);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_pwrite", bus.pwrite, 1'b0);
    check("rst_paddr", bus.paddr, 12'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    #1;
    check("post_rst_req_ready", bus.req_ready, 1'b1);

    // Zero-wait write then read
    xfer("wr010", 1'b1, 12'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1);
    xfer("rd010", 1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1);

    // Three wait states on a read
    xfer("wr020", 1'b1, 12'h020, 32'h1234_5678, 32'h0, 1'b0, 3, 1);
    n_waits = 3;
    xfer("rd020_wait", 1'b0, 12'h020, 32'h0, 32'h1234_5678, 1'b0, 6, 4);
    n_waits = 0;

    // Back-to-back writes with req_valid held high
    @(negedge pclk);
    b2b_idx       = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = b2b_addr[0];
    bus.req_wdata = b2b_data[0];
    for (int c = 0; c < 16; c++) begin
      #1;
      psel_tr[c] = bus.psel;
      rsp_tr[c]  = bus.rsp_valid;
      b2b_acc    = bus.req_valid && bus.req_ready;
      @(posedge pclk);
      #1;
      if (b2b_acc) begin
        b2b_idx++;
        if (b2b_idx < 3) begin
          bus.req_addr  = b2b_addr[b2b_idx];
          bus.req_wdata = b2b_data[b2b_idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      @(negedge pclk);
    end
    check("b2b_psel_trace", psel_tr, 16'b0000_0000_0111_1110);
    check("b2b_rsp_trace", rsp_tr, 16'b0000_0000_1010_1000);
    xfer("b2b_rd001", 1'b0, 12'h001, 32'h0, 32'h1111_0001, 1'b0, 3, 1);
    xfer("b2b_rd003", 1'b0, 12'h003, 32'h0, 32'h3333_0003, 1'b0, 3, 1);

    // Timeout abort, then a normal transfer
    force_stall = 1'b1;
    xfer("timeout", 1'b0, 12'h030, 32'h0, 32'h0, 1'b1, 18, 16);
    force_stall = 1'b0;
    check("timeout_psel_low", bus.psel, 1'b0);
    xfer("after_timeout", 1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1);

    // Reset during an ACCESS wait state
    force_stall = 1'b1;
    @(negedge pclk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 12'h040;
    @(posedge pclk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) @(negedge pclk);
    check("mid_penable_before_rst", bus.penable, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    check("mid_rst_psel", bus.psel, 1'b0);
    check("mid_rst_penable", bus.penable, 1'b0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) @(negedge pclk);
    presetn     = 1'b1;
    force_stall = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    n_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (bus.rsp_valid || bus.psel) n_bad++;
    end
    check("mid_rst_no_stale", n_bad, 0);
    xfer("after_rst", 1'b0, 12'h020, 32'h0, 32'h1234_5678, 1'b0, 3, 1);

    // Idle hold after a write
    xfer("wr0ab", 1'b1, 12'h0AB, 32'hA5A5_A5A5, 32'h0, 1'b0, 3, 1);
    n_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk);
      if (bus.psel || bus.penable || bus.rsp_valid || (bus.paddr !== 12'h0AB) ||
          (bus.pwdata !== 32'hA5A5_A5A5) || (bus.pwrite !== 1'b1))
        n_bad++;
    end
    check("idle_hold_bad_cycles", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that sits directly upstream of the team's APB memory slave.
- Converts a valid/ready command interface (from a CPU-side or test sequencer) into compliant APB SETUP/ACCESS phases on the psel/penable/pwrite/paddr/pwdata bus.
- Returns read data and completion status as a one-cycle response pulse.
- Adds a wait-state timeout so a slave that never asserts pready cannot hang the requester.

Parameters:
- addrWidth, 12, APB address width; matches the slave.
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  input  1  clock
- presetn  input  1  asynchronous active-low reset
- req_valid  input  1  command request
- req_ready  output  1  command accepted when req_valid && req_ready at posedge
- req_write  input  1  1=write, 0=read
- req_addr  input  addrWidth  transfer address
- req_wdata  input  32  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  1 = timeout abort
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  addrWidth  APB address
- pwdata  output  32  APB write data
- pready  input  1  slave ready
- prdata  input  32  slave read data

Behaviour:
- One clock, pclk. Reset presetn is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0 (req_ready, rsp_*, psel, penable, pwrite, paddr, pwdata); timeout counter 0.
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0. Always exactly 1 cycle, then ACCESS.
  - ACCESS: psel=1, penable=1.
- psel and penable decode from the state register only, so they are glitch-free.
- req_ready = (state==IDLE) || (state==ACCESS && pready). This is the only combinational path from pready; the timeout-abort cycle does not accept.
- On acceptance, register req_write/req_addr into pwrite/paddr. pwdata = req_wdata for writes, 0 for reads. Next state SETUP.
- paddr, pwrite and pwdata are stable from SETUP until ACCESS completes. In IDLE they hold their last value.
- ACCESS with pready=1:
  - rsp_valid=1 next cycle; rsp_rdata = prdata sampled at that edge for reads, 0 for writes; rsp_err=0.
  - Next state SETUP if a new request is accepted in the same cycle (back-to-back, psel stays high), else IDLE.
- ACCESS with pready=0: stay in ACCESS and increment the wait counter. The counter clears on entering SETUP.
- Timeout (TIMEOUT>0): when the counter reaches TIMEOUT-1 with pready=0, go to IDLE and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0. Counter width is $clog2(TIMEOUT+1).
- Latency: a zero-wait transfer is accepted at edge N, runs SETUP in cycle N+1 and ACCESS in cycle N+2, and rsp_valid is high in cycle N+3. Each wait state adds 1 cycle.
- rsp_valid is never high for 2 consecutive cycles unless two transfers complete back-to-back. There is no response backpressure.
- A req_valid deassert while not ready has no effect. Requests are never dropped once accepted.
- Reset mid-transfer: the bus returns to idle immediately (psel=penable=0) and no response is issued.

Decomposition:
- Package apb_pkg: typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS}; localparam APB_DATA_W=32.
- The slave imports the same enum.
- One natural sub-module: apb_wait_timer, the wait-state counter with clear, enable and expired flag, parameterised by TIMEOUT.

Test Plan:
- Write then read, zero-wait slave: write addr 0x010 data 0xDEADBEEF, then read addr 0x010 -> APB shows SETUP 1 cycle then ACCESS 1 cycle; rsp_valid 3 cycles after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Wait states: slave holds pready low 3 cycles on read of 0x020 returning 0x12345678 -> penable high 4 cycles, paddr stable throughout, rsp_valid 6 cycles after accept with rsp_rdata=0x12345678.
- Back-to-back: req_valid held high with 3 writes to 0x001/0x002/0x003 -> psel stays 1 continuously; SETUP-ACCESS pairs repeat every 2 cycles; three rsp_valid pulses 2 cycles apart.
- Timeout: TIMEOUT=16 with pready tied 0 -> after 16 ACCESS cycles psel drops; rsp_valid=1, rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- Reset mid-ACCESS: assert presetn=0 during a wait state -> psel, penable and rsp_valid are 0 asynchronously; after release req_ready=1 and no stale response appears.
- Idle hold: no requests for 10 cycles after a write of 0xA5A5A5A5 -> psel=penable=0, paddr/pwdata unchanged, rsp_valid=0.
